// File: rtl/serial_xor_packer.sv
// Packs a serial bit stream into WIDTH-bit words with XOR parity and presents
// each word on a one-entry valid/ready output register.
module serial_xor_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_parity_q, out_parity_d;
  logic             in_fire, last_bit;

  // Only the word-completing bit waits on a full output register; partial
  // bits always enter, so the next word overlaps the pending one.
  assign last_bit = (cnt_q == LAST);
  assign in_ready = !(out_valid_q && !out_ready && last_bit);
  assign in_fire  = in_valid && in_ready;

  assign shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], in_bit} : {in_bit, sr_q[WIDTH-1:1]};

  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      sr_d = shifted;
      if (last_bit) begin
        out_data_d   = shifted;
        out_parity_d = acc_q ^ in_bit;
        out_valid_d  = 1'b1;
        cnt_d        = '0;
        acc_d        = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = acc_q ^ in_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign busy       = (cnt_q != '0);

endmodule
